// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the raw pins, deserialises 11-bit frames
// and folds make/break (E0/F0 prefixed) scan codes into a five-key pressed mask.
`timescale 1ns/1ps
module ps2_key_decoder #(
  parameter int TIMEOUT     = 25000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       clr,
  output logic [4:0] keydown,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s, data_s, fall;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [4:0]    keydown_q, keydown_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic          code_valid_q, code_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          byte_done;
  logic [4:0]    key_bit;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_s;
    end
  end

  // WASD and the arrow keys deliberately map onto the same bits.
  function automatic logic [4:0] key_lookup(input logic ext, input logic [7:0] code);
    case ({ext, code})
      9'h01D, 9'h175: key_lookup = 5'b10000;
      9'h01B, 9'h172: key_lookup = 5'b01000;
      9'h01C, 9'h16B: key_lookup = 5'b00100;
      9'h023, 9'h174: key_lookup = 5'b00010;
      9'h029:         key_lookup = 5'b00001;
      default:        key_lookup = 5'b00000;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_ok_d     = par_ok_q;
    tmo_d        = (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);
    ext_d        = ext_q;
    brk_d        = brk_q;
    keydown_d    = keydown_q;
    scan_code_d  = scan_code_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    byte_done    = 1'b0;
    key_bit      = key_lookup(ext_q, shift_q);

    case (state_q)
      IDLE: if (fall) begin
        if (!data_s) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      DATA: if (fall) begin
        shift_d   = {data_s, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        par_ok_d = ^{shift_q, data_s};
        state_d  = STOP;
      end
      STOP: if (fall) begin
        state_d = IDLE;
        if (data_s && par_ok_q) begin
          scan_code_d  = shift_q;
          code_valid_d = 1'b1;
          byte_done    = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled frame is abandoned, but a pending E0/F0 prefix survives it.
    if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT - 1)) begin
      frame_err_d = 1'b1;
      state_d     = IDLE;
      shift_d     = '0;
      bit_cnt_d   = 3'd0;
      tmo_d       = '0;
    end

    if (clr) begin
      keydown_d = 5'b00000;
      ext_d     = 1'b0;
      brk_d     = 1'b0;
    end else if (byte_done) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        keydown_d = brk_q ? (keydown_q & ~key_bit) : (keydown_q | key_bit);
        ext_d     = 1'b0;
        brk_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_ok_q     <= 1'b0;
      tmo_q        <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      keydown_q    <= 5'b00000;
      scan_code_q  <= 8'h00;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_ok_q     <= par_ok_d;
      tmo_q        <= tmo_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      keydown_q    <= keydown_d;
      scan_code_q  <= scan_code_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign keydown    = keydown_q;
  assign scan_code  = scan_code_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: stimulus queues hand-computed expectations,
// a monitor pops and compares them whenever code_valid or frame_err fires.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       clr = 1'b0;
  logic [4:0] keydown;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;

  ps2_key_decoder #(.TIMEOUT(25000), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .clr(clr),
    .keydown(keydown), .scan_code(scan_code), .code_valid(code_valid), .frame_err(frame_err)
  );

  always #20 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] sc;
    logic [4:0] kd;
  } ev_t;

  typedef struct {
    bit         is_end;
    int         tag;
    logic [4:0] kd;
    logic [7:0] sc;
  } snap_t;

  ev_t   exp_q[$];
  snap_t snap_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
  endtask

  // Monitor: the only process that compares and counts.
  initial begin
    ev_t   e;
    snap_t s;
    forever begin
      @(negedge clk);
      if (code_valid || frame_err) begin
        chk("exclusive_pulse", {31'd0, code_valid & frame_err}, 32'd0);
        chk("output_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          $display("event: code_valid=%0b frame_err=%0b scan_code=%02h keydown=%05b (exp err=%0b sc=%02h kd=%05b)",
                   code_valid, frame_err, scan_code, keydown, e.is_err, e.sc, e.kd);
          chk("event_kind", {31'd0, frame_err}, {31'd0, e.is_err});
          if (!e.is_err) chk("scan_code", {24'd0, scan_code}, {24'd0, e.sc});
          chk("keydown", {27'd0, keydown}, {27'd0, e.kd});
        end
      end
      if (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        if (s.is_end) begin
          chk("scoreboard_drained", exp_q.size(), 32'd0);
          $display("%0d/%0d checks passed", n_pass, n_checks);
          $finish;
        end else begin
          $display("snapshot %0d: keydown=%05b scan_code=%02h cv=%0b fe=%0b", s.tag, keydown, scan_code,
                   code_valid, frame_err);
          chk($sformatf("snapshot%0d", s.tag), {17'd0, keydown, scan_code, code_valid, frame_err},
              {17'd0, s.kd, s.sc, 2'b00});
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not reach its end (actual=timeout required=finish)");
    $fatal(1);
  end

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (4) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (8) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic push_ev(input bit is_err, input logic [7:0] sc, input logic [4:0] kd);
    ev_t e;
    e.is_err = is_err; e.sc = sc; e.kd = kd;
    exp_q.push_back(e);
  endtask

  task automatic frame(input logic [7:0] b, input logic bad_par, input logic [4:0] kd);
    push_ev(bad_par, b, kd);
    $display("send: byte=%02h bad_parity=%0b expect keydown=%05b", b, bad_par, kd);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad_par);
    ps2_bit(1'b1);
    repeat (10) @(posedge clk);
  endtask

  task automatic snap(input int tag, input logic [4:0] kd, input logic [7:0] sc);
    snap_t s;
    s.is_end = 1'b0; s.tag = tag; s.kd = kd; s.sc = sc;
    snap_q.push_back(s);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    snap_t s_end;
    repeat (5) @(posedge clk);
    snap(0, 5'b00000, 8'h00);
    @(posedge clk); #1 rst = 1'b1;
    repeat (10) @(posedge clk);

    // Space make then break
    frame(8'h29, 1'b0, 5'b00001);
    frame(8'hF0, 1'b0, 5'b00001);
    frame(8'h29, 1'b0, 5'b00000);

    // Extended arrows
    frame(8'hE0, 1'b0, 5'b00000);
    frame(8'h75, 1'b0, 5'b10000);
    frame(8'hE0, 1'b0, 5'b10000);
    frame(8'h6B, 1'b0, 5'b10100);
    frame(8'hE0, 1'b0, 5'b10100);
    frame(8'hF0, 1'b0, 5'b10100);
    frame(8'h75, 1'b0, 5'b00100);
    frame(8'hE0, 1'b0, 5'b00100);
    frame(8'hF0, 1'b0, 5'b00100);
    frame(8'h6B, 1'b0, 5'b00000);

    // Parity error, then a good frame
    frame(8'h1C, 1'b1, 5'b00000);
    frame(8'h1C, 1'b0, 5'b00100);

    // Timeout on a partial frame
    push_ev(1'b1, 8'h00, 5'b00100);
    $display("send: partial frame (start + 4 bits), expect timeout");
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (25100) @(posedge clk);
    frame(8'h23, 1'b0, 5'b00110);

    // All keys pressed, then clr
    frame(8'h1D, 1'b0, 5'b10110);
    frame(8'h1B, 1'b0, 5'b11110);
    frame(8'h29, 1'b0, 5'b11111);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    snap(1, 5'b00000, 8'h29);
    frame(8'hF0, 1'b0, 5'b00000);
    frame(8'h29, 1'b0, 5'b00000);

    // Asynchronous reset mid-frame
    frame(8'h1B, 1'b0, 5'b01000);
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    #7 rst = 1'b0;
    ps2_data = 1'b1;
    snap(2, 5'b00000, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    frame(8'h1D, 1'b0, 5'b10000);

    repeat (50) @(posedge clk);
    s_end.is_end = 1'b1; s_end.tag = 99; s_end.kd = 5'b00000; s_end.sc = 8'h00;
    snap_q.push_back(s_end);
  end

endmodule
